// File: rtl/u_pkg.sv
// Shared types and helpers for the unary (thermometer) datapath.
package u_pkg;

  localparam int unsigned U_MIN_LEN   = 1;
  localparam int unsigned U_LEN_MAX_W = 16;

  typedef logic [U_LEN_MAX_W-1:0] u_len_t;

  typedef struct packed {
    u_len_t len;
    logic   inv;
    logic   err;
  } u_s1_t;

  function automatic int unsigned u_len_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/u_skid.sv
// Two-entry valid/ready skid buffer; head entry drives the output directly.
module u_skid #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  input  logic          i_ready,
  output logic          o_full
);

  logic [1:0]    count_q, count_d;
  logic [DW-1:0] ent0_q, ent0_d;
  logic [DW-1:0] ent1_q, ent1_d;
  logic          push, pop;

  assign o_valid = (count_q != 2'd0);
  assign o_full  = (count_q == 2'd2);
  assign o_data  = ent0_q;
  // A full buffer still takes a beat in the same cycle the head leaves.
  assign o_ready = !o_full || i_ready;
  assign pop     = o_valid && i_ready;
  assign push    = i_valid && o_ready;

  always_comb begin
    count_d = count_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) ent0_d = i_data;
        else                 ent1_d = i_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        ent0_d  = ent1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          ent0_d = i_data;
        end else begin
          ent0_d = ent1_q;
          ent1_d = i_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      ent0_q  <= '0;
      ent1_q  <= '0;
    end else begin
      count_q <= count_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
    end
  end

endmodule

// File: rtl/u_enc.sv
// Streaming binary-to-thermometer encoder: range check, per-bit encode, skid output.
module u_enc
  import u_pkg::*;
#(
  parameter int W                    = 16,
  parameter int P_EMIT_COMPLIMENT_EN = 1,
  parameter int LEN_W                = u_len_w(W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_inv,
  output logic             o_ready,
  output logic             o_valid,
  output logic [W-1:0]     o_code,
  output logic             o_err,
  input  logic             i_ready
);

  localparam logic INV_EN = (P_EMIT_COMPLIMENT_EN != 0);

  logic   s1_valid_q, s1_valid_d;
  u_s1_t  s1_q, s1_d;
  logic   accept, s1_adv;
  logic   skid_in_ready, skid_full;
  logic [W-1:0] mask, code;
  u_len_t len_in;

  assign len_in = u_len_t'(i_len);
  assign accept = i_valid && o_ready;
  assign s1_adv = s1_valid_q && skid_in_ready;
  assign o_ready = !skid_full;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (s1_adv) s1_valid_d = 1'b0;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_d.len   = len_in;
      s1_d.inv   = i_inv && INV_EN;
      s1_d.err   = (len_in < u_len_t'(U_MIN_LEN)) || (len_in > u_len_t'(W - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
    end
  end

  // Compare is wider than LEN_W so the largest encodable length cannot wrap.
  for (genvar gi = 0; gi < W; gi++) begin : g_mask
    assign mask[gi] = (u_len_t'(gi) < s1_q.len);
  end

  assign code = s1_q.err ? '0 : (mask ^ {W{s1_q.inv}});

  u_skid #(.DW(W + 1)) u_skid_i (
    .clk     (clk),
    .rst     (rst),
    .i_valid (s1_valid_q),
    .i_data  ({s1_q.err, code}),
    .o_ready (skid_in_ready),
    .o_valid (o_valid),
    .o_data  ({o_err, o_code}),
    .i_ready (i_ready),
    .o_full  (skid_full)
  );

endmodule

// File: tb/tb_u_enc.sv
// Bench for u_enc: directed vectors plus a queue model checked on every output transfer.
module tb_u_enc;
  localparam int W     = 16;
  localparam int LEN_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_valid = 1'b0;
  logic [LEN_W-1:0] i_len = '0;
  logic i_inv = 1'b0;
  logic i_ready = 1'b1;
  logic o_ready, o_valid, o_err;
  logic [W-1:0] o_code;
  logic o0_ready, o0_valid, o0_err;
  logic [W-1:0] o0_code;

  always #5 clk = ~clk;

  u_enc #(.W(W), .P_EMIT_COMPLIMENT_EN(1)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_len(i_len), .i_inv(i_inv),
    .o_ready(o_ready), .o_valid(o_valid), .o_code(o_code), .o_err(o_err), .i_ready(i_ready)
  );

  u_enc #(.W(W), .P_EMIT_COMPLIMENT_EN(0)) dut0 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_len(i_len), .i_inv(i_inv),
    .o_ready(o0_ready), .o_valid(o0_valid), .o_code(o0_code), .o_err(o0_err), .i_ready(i_ready)
  );

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [W-1:0] c1;
    logic [W-1:0] c0;
    logic         err;
  } beat_t;

  beat_t exp_q[$];
  int cyc = 0, xfer_cnt = 0, first_x = -1, last_x = -1;
  logic prev_stall = 1'b0;
  logic [W-1:0] prev_code = '0;

  function automatic logic [W-1:0] model_code(int n, bit inv, bit en);
    logic [W-1:0] c;
    c = '0;
    if (n < 1 || n > W - 1) return '0;
    for (int k = 0; k < W; k++) if (k < n) c[k] = 1'b1;
    if (inv && en) c = ~c;
    return c;
  endfunction

  // Unary admission with complement admission enabled.
  function automatic bit admits(logic [W-1:0] code);
    logic [W-1:0] c, cp1;
    c = code;
    if (!c[0]) c = ~c;
    cp1 = c + 1'b1;
    return (c != '0) && (c != '1) && ((c & cp1) == '0);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Compare process: model queue filled on accept, drained on transfer.
  always @(negedge clk) begin
    beat_t e;
    int n;
    cyc++;
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", o_valid, 1);
        check("hold_code", o_code, prev_code);
      end
      if (!o_ready || !o0_ready) check("ready_low_only_full", exp_q.size() >= 2, 1);
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_beat: got code %h, required no beat", o_code);
        end else begin
          e = exp_q.pop_front();
          check("code", o_code, e.c1);
          check("err", o_err, e.err);
          check("code_p0", o0_code, e.c0);
          check("err_p0", o0_err, e.err);
          if (!e.err) check("unary_admit", admits(o_code), 1);
        end
        xfer_cnt++;
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
      end
      if (i_valid && o_ready) begin
        n = int'(i_len);
        e.c1  = model_code(n, i_inv, 1'b1);
        e.c0  = model_code(n, i_inv, 1'b0);
        e.err = (n < 1) || (n > W - 1);
        exp_q.push_back(e);
      end
      prev_stall = o_valid && !i_ready;
      prev_code  = o_code;
    end
  end

  typedef struct {
    int           len;
    bit           inv;
    logic [W-1:0] c1;
    bit           err;
    logic [W-1:0] c0;
  } vec_t;

  vec_t vecs[9] = '{
    '{5,  1'b0, 16'h001F, 1'b0, 16'h001F},
    '{5,  1'b1, 16'hFFE0, 1'b0, 16'h001F},
    '{1,  1'b0, 16'h0001, 1'b0, 16'h0001},
    '{15, 1'b0, 16'h7FFF, 1'b0, 16'h7FFF},
    '{0,  1'b0, 16'h0000, 1'b1, 16'h0000},
    '{16, 1'b0, 16'h0000, 1'b1, 16'h0000},
    '{31, 1'b1, 16'h0000, 1'b1, 16'h0000},
    '{15, 1'b1, 16'h8000, 1'b0, 16'h7FFF},
    '{1,  1'b1, 16'hFFFE, 1'b0, 16'h0001}
  };

  // Called just after a rising edge with an empty pipeline.
  task automatic single(vec_t v);
    i_valid = 1'b1;
    i_len   = LEN_W'(v.len);
    i_inv   = v.inv;
    i_ready = 1'b1;
    check("single_ready", o_ready, 1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    check("lat_t1_novalid", o_valid, 0);
    @(posedge clk); #1;
    check("lat_t2_valid", o_valid, 1);
    check("single_code", o_code, v.c1);
    check("single_err", o_err, v.err);
    check("single_code_p0", o0_code, v.c0);
    @(posedge clk); #1;
  endtask

  task automatic drain(bit rand_ready);
    int budget;
    budget = 200;
    while ((exp_q.size() != 0 || o_valid) && budget > 0) begin
      if (rand_ready) i_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      budget--;
    end
    i_ready = 1'b1;
    if (budget == 0) check("drain_timeout", 0, 1);
  endtask

  initial begin
    int budget;
    bit ok;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_code", o_code, 0);
    check("rst_err", o_err, 0);
    rst = 1'b0;
    check("rst_ready", o_ready, 1);

    foreach (vecs[i]) single(vecs[i]);

    // Back-to-back stream under continuous ready.
    xfer_cnt = 0; first_x = -1; last_x = -1;
    for (int n = 1; n <= 15; n++) begin
      i_valid = 1'b1;
      i_len   = LEN_W'(n);
      i_inv   = 1'b0;
      check("stream_ready", o_ready, 1);
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    drain(1'b0);
    check("stream_count", xfer_cnt, 15);
    check("stream_no_gap", last_x - first_x, 14);

    // Same stream under random backpressure.
    xfer_cnt = 0;
    for (int n = 1; n <= 15; n++) begin
      i_valid = 1'b1;
      i_len   = LEN_W'(n);
      i_inv   = n[0];
      budget  = 100;
      ok      = 1'b0;
      while (!ok && budget > 0) begin
        i_ready = 1'($urandom_range(0, 1));
        ok = o_ready;
        @(posedge clk); #1;
        budget--;
      end
      if (!ok) check("bp_accept_timeout", 0, 1);
    end
    i_valid = 1'b0;
    drain(1'b1);
    check("bp_count", xfer_cnt, 15);

    // Reset with two beats in flight, output stalled.
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_len   = LEN_W'(9);
    @(posedge clk); #1;
    i_len   = LEN_W'(10);
    @(posedge clk); #1;
    i_valid = 1'b0;
    rst     = 1'b1;
    @(posedge clk); #1;
    rst     = 1'b0;
    check("rst_mid_valid", o_valid, 0);
    check("rst_mid_code", o_code, 0);
    xfer_cnt = 0;
    single('{3, 1'b0, 16'h0007, 1'b0, 16'h0007});
    drain(1'b0);
    check("rst_mid_count", xfer_cnt, 1);

    check("final_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
